// File: rtl/case_state_arbiter.sv
// rtl/case_state_arbiter.sv - four-state grant scheduler sharing one resource among NREQ requesters
module case_state_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] rel,
    input  logic            prio_mode,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      grant_id,
    output logic            busy,
    output logic            timeout
);

    localparam int               IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [3:0]       gap_cnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] next_ptr;
    logic             mode_q;
    logic             own_rel;
    logic             own_req;
    logic             tenure_end;

    // Round-robin scans upward from ptr, wrapping; fixed priority takes the lowest index.
    function automatic logic [IDX_W-1:0] pick(input logic [NREQ-1:0] r,
                                              input logic [IDX_W-1:0] ptr,
                                              input logic             fixed);
        logic             found;
        logic [IDX_W-1:0] w;
        found = 1'b0;
        w     = '0;
        if (fixed) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && r[i]) begin
                    found = 1'b1;
                    w     = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && r[i] && (i >= int'(ptr))) begin
                    found = 1'b1;
                    w     = IDX_W'(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && r[i] && (i < int'(ptr))) begin
                    found = 1'b1;
                    w     = IDX_W'(i);
                end
            end
        end
        return w;
    endfunction

    always_comb begin
        winner     = pick(req, rr_ptr, mode_q);
        own_rel    = rel[owner];
        own_req    = req[owner];
        tenure_end = own_rel || !own_req || (hold_cnt == HOLD_LAST);
        next_ptr   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            mode_q   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    grant  <= '0;
                    mode_q <= prio_mode;
                    if (|req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ARB: begin
                    grant <= '0;
                    if (|req) begin
                        grant[winner] <= 1'b1;
                        grant_id      <= 3'(winner);
                        owner         <= winner;
                        hold_cnt      <= '0;
                        state         <= HOLD;
                        busy          <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (tenure_end) begin
                        grant   <= '0;
                        rr_ptr  <= next_ptr;
                        gap_cnt <= '0;
                        // A release or dropped request in the limit cycle is not a timeout.
                        timeout <= !own_rel && own_req;
                        if (HAS_GAP) begin
                            state <= GAP;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    grant <= '0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_state_arbiter.sv
// tb/tb_case_state_arbiter.sv - self-checking bench for case_state_arbiter
module tb_case_state_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
    localparam int GAP      = 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic            prio_mode;
    logic [NREQ-1:0] grant;
    logic [2:0]      grant_id;
    logic            busy;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    case_state_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .rel       (rel),
        .prio_mode (prio_mode),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner/age/cooldown bookkeeping derived from the scheduling rules.
    int              m_owner = -1;
    int              m_age   = 0;
    int              m_cool  = 0;
    int              m_ptr   = 0;
    bit              m_pend  = 0;
    bit              m_mode  = 0;
    bit              started = 0;
    logic [NREQ-1:0] e_grant = '0;
    logic [2:0]      e_id    = '0;
    logic            e_busy  = 1'b0;
    logic            e_to    = 1'b0;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int ptr, input bit fixed);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = fixed ? k : (ptr + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        started = 1;
        e_to    = 1'b0;
        if (!reset_n) begin
            m_owner = -1; m_age = 0; m_cool = 0; m_ptr = 0; m_pend = 0; m_mode = 0;
            e_busy  = 1'b0; e_id = '0;
        end else if (m_owner >= 0) begin
            if (rel[m_owner] || !req[m_owner] || m_age == MAX_HOLD - 1) begin
                e_to    = !rel[m_owner] && req[m_owner];
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
                m_cool  = GAP;
                e_busy  = (GAP > 0);
            end else begin
                m_age++;
            end
        end else if (m_pend) begin
            m_pend = 0;
            if (req == '0) begin
                e_busy = 1'b0;
            end else begin
                m_owner = model_pick(req, m_ptr, m_mode);
                m_age   = 0;
                e_busy  = 1'b1;
                e_id    = 3'(m_owner);
            end
        end else if (m_cool > 0) begin
            m_cool--;
            e_busy = (m_cool > 0);
        end else if (req != '0) begin
            m_pend = 1;
            m_mode = prio_mode;
            e_busy = 1'b1;
        end else begin
            e_busy = 1'b0;
        end
        e_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (grant !== e_grant || busy !== e_busy || timeout !== e_to ||
                (e_grant != '0 && grant_id !== e_id) || !$onehot0(grant)) begin
                errors++;
                $display("FAIL model t=%0t: grant=%b id=%0d busy=%b timeout=%b expected grant=%b id=%0d busy=%b timeout=%b",
                         $time, grant, grant_id, busy, timeout, e_grant, e_id, e_busy, e_to);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input string name, output int n);
        n = 0;
        while (grant == '0 && n < 40) begin
            tick();
            n++;
        end
        if (grant == '0) begin
            checks++;
            errors++;
            $display("FAIL %s: grant=0 after 40 cycles, expected nonzero", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        reset_n = 1'b0; req = 4'b1111; rel = '0; prio_mode = 1'b0;

        // 1: reset holds everything low despite requests, then 2-cycle grant latency
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_grant", 32'(grant), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_timeout", 32'(timeout), 32'h0);
        end
        reset_n = 1'b1;
        tick();
        check("lat_arb_grant", 32'(grant), 32'h0);
        check("lat_arb_busy", 32'(busy), 32'h1);
        tick();
        check("lat_grant", 32'(grant), 32'h1);
        req = '0;
        repeat (3) tick();

        // 2: single requester releases in its third cycle
        req = 4'b0100;
        wait_grant("single_wait", n);
        check("single_latency", 32'(n), 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("single_grant", 32'(grant), 32'h4);
            check("single_id", 32'(grant_id), 32'd2);
            if (i == 2) begin
                rel = 4'b0100;
                req = '0;
            end else begin
                tick();
            end
        end
        tick();
        rel = '0;
        check("single_gap_grant", 32'(grant), 32'h0);
        check("single_gap_busy", 32'(busy), 32'h1);
        tick();
        check("single_idle_busy", 32'(busy), 32'h0);

        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;

        // 3: round-robin rotation, non-owner rel ignored
        prio_mode = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'(1 << (k % 4));
            wait_grant("rr_wait", n);
            if (k > 0) check("rr_spacing", 32'(n), 32'd3);
            check("rr_grant", 32'(grant), 32'(exp_g));
            rel = ~grant;
            tick();
            check("rr_hold2", 32'(grant), 32'(exp_g));
            rel = grant;
            if (k == 4) req = '0;
            tick();
            rel = '0;
            check("rr_end", 32'(grant), 32'h0);
        end
        repeat (2) tick();

        // 4: fixed priority starves requester 3
        prio_mode = 1'b1;
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_grant("prio_wait", n);
            check("prio_grant", 32'(grant), 32'h2);
            tick();
            rel = grant;
            if (k == 3) req = '0;
            tick();
            rel = '0;
        end
        repeat (3) tick();

        // 5: timeout after MAX_HOLD cycles; release in the last cycle suppresses it
        prio_mode = 1'b0;
        req = 4'b0001;
        wait_grant("to_wait", n);
        len = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant == '0) break;
            len++;
        end
        check("to_length", 32'(len), 32'd8);
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_pulse_end", 32'(timeout), 32'h0);
        wait_grant("to_wait2", n);
        check("to_relatency", 32'(n), 32'd2);
        repeat (7) tick();
        rel = 4'b0001;
        req = '0;
        tick();
        rel = '0;
        check("to_rel_grant", 32'(grant), 32'h0);
        check("to_rel_timeout", 32'(timeout), 32'h0);
        repeat (2) tick();

        // 6: reset mid-tenure clears grant and the round-robin pointer
        req = 4'b0010;
        wait_grant("mid_wait1", n);
        rel = 4'b0010;
        req = '0;
        tick();
        rel = '0;
        repeat (2) tick();
        req = 4'b0001;
        wait_grant("mid_wait2", n);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_timeout", 32'(timeout), 32'h0);
        reset_n = 1'b1;
        req = 4'b0110;
        wait_grant("mid_wait3", n);
        check("mid_rr_grant", 32'(grant), 32'h2);
        check("mid_rr_id", 32'(grant_id), 32'd1);
        req = '0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
